vdma_buffer_sequencer: RTL and testbench
========================================

// Module: vdma_buffer_sequencer
// PURPOSE
//  Multi-buffer (default triple) frame scheduler for the AXI4->AXI4S read VDMA. Tracks which frame buffer the
//  producer writes and which the VDMA displays. Programs the VDMA over its Wishbone register port as a single
//  master: PARAM_ADDR, then CTL_CONTROL, then polls until the VDMA has taken the update.
// PARAMETERS
//  WB_ADR_WIDTH   8              Wishbone address width (byte offsets)
//  WB_DAT_WIDTH   32             Wishbone data width
//  WB_SEL_WIDTH   WB_DAT_WIDTH/8 byte-select width
//  ADDR_WIDTH     32             frame buffer address width
//  BUF_NUM        3              number of frame buffers (>=3)
//  INDEX_WIDTH    2              width of buffer indices (2**INDEX_WIDTH >= BUF_NUM)
//  POLL_WAIT      15             idle cycles between CTL_CONTROL polls
// PORTS
//  s_wb_clk_i   in   1             clock (all logic)
//  s_wb_rst_i   in   1             synchronous active-high reset
//  enable       in   1             level; 1 = run VDMA, 0 = stop it
//  base_addr    in   ADDR_WIDTH    address of buffer 0 (held stable while enable=1)
//  buf_size     in   ADDR_WIDTH    byte distance between buffers
//  wr_done      in   1             1-cycle pulse: producer finished buffer wr_index
//  wr_index     out  INDEX_WIDTH   buffer the producer must write next
//  wr_valid     out  1             wr_index is free and may be written
//  rd_index     out  INDEX_WIDTH   buffer the VDMA has accepted for display
//  busy         out  1             FSM not in IDLE
//  m_wb_adr_o   out  WB_ADR_WIDTH  master address
//  m_wb_dat_o   out  WB_DAT_WIDTH  master write data
//  m_wb_dat_i   in   WB_DAT_WIDTH  master read data
//  m_wb_we_o    out  1             write enable
//  m_wb_sel_o   out  WB_SEL_WIDTH  byte selects (always all ones)
//  m_wb_stb_o   out  1             strobe
//  m_wb_ack_i   in   1             acknowledge (single or multi-cycle)
// BEHAVIOUR
//  Reset: rd_index=0, wr_index=1, wr_valid=1, busy=0, m_wb_stb_o=0, m_wb_we_o=0, m_wb_adr_o=0, m_wb_dat_o=0.
//   Internal ready_valid=0, pend_valid=0, stop_done=1. Reset takes effect on the edge where it is sampled,
//   mid-transaction too: stb drops and any in-flight sequence is abandoned.
//  Slot bookkeeping: rd (displayed), pend (in flight, if pend_valid), ready (latest complete, if ready_valid), wr.
//   free(i) = i not rd, not pend (if valid), not ready (if valid), not wr.
//  wr_done with wr_valid=1: ready<=wr_index, ready_valid<=1; an older ready is dropped and becomes free.
//   wr_index<=first free i after wr_index, modulo BUF_NUM; if none, wr_valid<=0.
//  wr_done with wr_valid=0 is ignored.
//  wr_valid=0 and a slot frees (pickup done): wr_index<=that slot, wr_valid<=1 on the same edge.
//  Registered outputs update one cycle after the causing edge.
//  Bus cycle: stb/we/adr/dat are held constant until the cycle ack_i=1; stb deasserts the next cycle.
//   No back-to-back strobe.
//  FSM:
//   IDLE:    enable & ready_valid -> pend<=ready, pend_valid<=1, ready_valid<=0, stop_done<=0 -> WR_ADDR.
//            !enable & !stop_done -> STOP.
//   WR_ADDR: write adr 0x20, dat = base_addr + pend*buf_size (low ADDR_WIDTH bits, wrap ignored);
//            ack -> WR_CTL.
//   WR_CTL:  write adr 0x10, dat = 32'h3 (enable|update); ack -> POLL.
//   POLL:    read adr 0x10; ack & dat_i[1]==0 -> rd<=pend, pend_valid<=0 -> IDLE.
//            ack & dat_i[1]==1 -> WAIT.
//   WAIT:    count POLL_WAIT cycles -> POLL.
//   STOP:    write adr 0x10, dat = 0; ack -> stop_done<=1 -> IDLE.
//  enable falling mid-sequence: the sequence completes; STOP follows from IDLE.
//  wr_done in the same cycle as the IDLE->WR_ADDR latch: the latch uses the old ready.
//   The new ready_valid is set after the latch; wr_done wins on ready_valid.
//  busy=1 in every state except IDLE.
// TESTING
//  1 base=0x1000_0000, size=0x0010_0000, enable=1, one wr_done -> writes 0x20<=0x1010_0000, then 0x10<=3.
//    Poll returns 0 -> rd_index=1, wr_index=2.
//  2 Poll returns bit1=1 twice, then 0 -> 3 reads spaced POLL_WAIT+ idle cycles; rd_index changes only after third ack.
//  3 Three wr_done pulses during one in-flight update (BUF_NUM=3) -> wr_valid=0 after second.
//    Third pulse ignored; wr_valid=1 on pickup.
//  4 Ack delayed 5 cycles -> adr/dat/stb stable all 5 cycles; stb low the cycle after ack.
//  5 enable 1->0 while in WAIT -> poll finishes, then single write 0x10<=0; no further bus cycles.
//  6 s_wb_rst_i pulsed while stb=1 in WR_CTL -> next cycle stb=0, rd_index=0, wr_index=1, wr_valid=1, busy=0.

Source files
------------

// File: rtl/vdma_buffer_sequencer.sv
// Frame buffer scheduler for the read VDMA. It tracks the displayed, in-flight,
// ready and write slots, and programs the VDMA over a single-master Wishbone port.
module vdma_buffer_sequencer #(
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int BUF_NUM      = 3,
  parameter int INDEX_WIDTH  = 2,
  parameter int POLL_WAIT    = 15
) (
  input  logic                    s_wb_clk_i,
  input  logic                    s_wb_rst_i,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   buf_size,
  input  logic                    wr_done,
  output logic [INDEX_WIDTH-1:0]  wr_index,
  output logic                    wr_valid,
  output logic [INDEX_WIDTH-1:0]  rd_index,
  output logic                    busy,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic                    m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i
);

  localparam int CNT_W = $clog2(POLL_WAIT + 2);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL   = WB_ADR_WIDTH'(8'h10);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM = WB_ADR_WIDTH'(8'h20);
  localparam logic [WB_DAT_WIDTH-1:0] CTL_RUN   = WB_DAT_WIDTH'(3);

  typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_CTL, S_POLL, S_WAIT, S_STOP} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] ready_idx, pend_idx;
  logic                   ready_valid, pend_valid, stop_done;
  logic [CNT_W-1:0]       wait_cnt;

  logic                   latch, pickup, wr_accept, pend_valid_nx, nxt_found;
  logic [INDEX_WIDTH-1:0] rd_nx, pend_nx, nxt_wr, cand;
  logic [ADDR_WIDTH-1:0]  frame_addr;
  logic                   unused_dat;

  assign m_wb_sel_o = '1;
  // Only the update-pending bit of CTL_CONTROL matters on reads.
  assign unused_dat = ^{m_wb_dat_i[WB_DAT_WIDTH-1:2], m_wb_dat_i[0]};

  // Events that change slot ownership on this edge.
  assign latch         = (state == S_IDLE) && enable && ready_valid;
  assign pickup        = (state == S_POLL) && m_wb_stb_o && m_wb_ack_i && !m_wb_dat_i[1];
  assign wr_accept     = wr_done && wr_valid;
  assign rd_nx         = pickup ? pend_idx : rd_index;
  assign pend_nx       = latch ? ready_idx : pend_idx;
  assign pend_valid_nx = latch || (pend_valid && !pickup);
  assign frame_addr    = base_addr + ADDR_WIDTH'(pend_idx) * buf_size;

  // First free slot after wr_index, judged against post-edge ownership; the
  // finished wr slot becomes ready and the previous ready is dropped.
  always_comb begin
    nxt_found = 1'b0;
    nxt_wr    = wr_index;
    cand      = '0;
    for (int k = BUF_NUM - 1; k >= 1; k--) begin
      cand = INDEX_WIDTH'((int'(wr_index) + k) % BUF_NUM);
      if (cand != rd_nx && !(pend_valid_nx && cand == pend_nx) && cand != wr_index) begin
        nxt_found = 1'b1;
        nxt_wr    = cand;
      end
    end
  end

  // Slot bookkeeping: displayed, ready and producer write slot.
  always_ff @(posedge s_wb_clk_i) begin
    if (s_wb_rst_i) begin
      rd_index    <= '0;
      wr_index    <= INDEX_WIDTH'(1);
      wr_valid    <= 1'b1;
      ready_idx   <= '0;
      ready_valid <= 1'b0;
    end else begin
      if (pickup) rd_index <= pend_idx;
      if (wr_accept) begin
        // A new frame wins over the latch clearing ready_valid.
        ready_idx   <= wr_index;
        ready_valid <= 1'b1;
        if (nxt_found) wr_index <= nxt_wr;
        else           wr_valid <= 1'b0;
      end else begin
        if (latch) ready_valid <= 1'b0;
        if (!wr_valid && pickup) begin
          wr_index <= rd_index;
          wr_valid <= 1'b1;
        end
      end
    end
  end

  // Register-programming sequencer; each bus state raises stb once, holds the
  // cycle until ack, then drops stb so strobes are never back to back.
  always_ff @(posedge s_wb_clk_i) begin
    if (s_wb_rst_i) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_we_o  <= 1'b0;
      m_wb_adr_o <= '0;
      m_wb_dat_o <= '0;
      pend_idx   <= '0;
      pend_valid <= 1'b0;
      stop_done  <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (latch) begin
            pend_idx   <= ready_idx;
            pend_valid <= 1'b1;
            stop_done  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_WR_ADDR;
          end else if (!enable && !stop_done) begin
            busy  <= 1'b1;
            state <= S_STOP;
          end
        end
        S_WR_ADDR: begin
          if (!m_wb_stb_o) begin
            m_wb_stb_o <= 1'b1;
            m_wb_we_o  <= 1'b1;
            m_wb_adr_o <= ADR_PARAM;
            m_wb_dat_o <= WB_DAT_WIDTH'(frame_addr);
          end else if (m_wb_ack_i) begin
            m_wb_stb_o <= 1'b0;
            m_wb_we_o  <= 1'b0;
            state      <= S_WR_CTL;
          end
        end
        S_WR_CTL: begin
          if (!m_wb_stb_o) begin
            m_wb_stb_o <= 1'b1;
            m_wb_we_o  <= 1'b1;
            m_wb_adr_o <= ADR_CTL;
            m_wb_dat_o <= CTL_RUN;
          end else if (m_wb_ack_i) begin
            m_wb_stb_o <= 1'b0;
            m_wb_we_o  <= 1'b0;
            state      <= S_POLL;
          end
        end
        S_POLL: begin
          if (!m_wb_stb_o) begin
            m_wb_stb_o <= 1'b1;
            m_wb_we_o  <= 1'b0;
            m_wb_adr_o <= ADR_CTL;
            m_wb_dat_o <= '0;
          end else if (m_wb_ack_i) begin
            m_wb_stb_o <= 1'b0;
            if (m_wb_dat_i[1]) begin
              wait_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              pend_valid <= 1'b0;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (int'(wait_cnt) + 1 >= POLL_WAIT) state <= S_POLL;
          else                                 wait_cnt <= wait_cnt + 1'b1;
        end
        S_STOP: begin
          if (!m_wb_stb_o) begin
            m_wb_stb_o <= 1'b1;
            m_wb_we_o  <= 1'b1;
            m_wb_adr_o <= ADR_CTL;
            m_wb_dat_o <= '0;
          end else if (m_wb_ack_i) begin
            m_wb_stb_o <= 1'b0;
            m_wb_we_o  <= 1'b0;
            stop_done  <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdma_buffer_sequencer.sv
// Bench for vdma_buffer_sequencer: Wishbone slave with programmable ack delay
// and poll answers, plus a slot-set reference model checked every cycle.
module tb_vdma_buffer_sequencer;
  localparam int AW = 32, DW = 32, BN = 3, IW = 2, PW = 15;

  logic          clk = 1'b0;
  logic          rst, enable, wr_done;
  logic [AW-1:0] base_addr, buf_size;
  logic [IW-1:0] wr_index, rd_index;
  logic          wr_valid, busy;
  logic [7:0]    m_wb_adr_o;
  logic [DW-1:0] m_wb_dat_o, m_wb_dat_i;
  logic          m_wb_we_o, m_wb_stb_o, m_wb_ack_i;
  logic [3:0]    m_wb_sel_o;

  always #5 clk = ~clk;

  vdma_buffer_sequencer #(.WB_ADR_WIDTH(8), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(4),
    .ADDR_WIDTH(AW), .BUF_NUM(BN), .INDEX_WIDTH(IW), .POLL_WAIT(PW)) dut (
    .s_wb_clk_i(clk), .s_wb_rst_i(rst), .enable(enable), .base_addr(base_addr),
    .buf_size(buf_size), .wr_done(wr_done), .wr_index(wr_index), .wr_valid(wr_valid),
    .rd_index(rd_index), .busy(busy), .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
    .m_wb_dat_i(m_wb_dat_i), .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o),
    .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i));

  int n_cmp = 0, n_err = 0, cyc = 0;

  // slave state
  int          ack_dly = 0, stb_age = 0, poll_busy = 0, last_hold = 0;
  bit          rand_mode = 0, stb_prev = 0, ack_prev = 0;
  logic [7:0]  cap_adr;
  logic [31:0] cap_dat, last_frame_dat;
  logic        cap_we;

  // reference model: phase of the programming sequence plus slot ownership
  typedef enum {P_IDLE, P_ADDR, P_CTL, P_POLL, P_STOP} phase_t;
  phase_t ph = P_IDLE;
  int m_rd, m_wr, m_pend, m_ready;
  bit m_wr_v, m_pend_v, m_ready_v, m_stop_done;
  int last_poll_ack = -1, poll_cnt = 0, stop_cnt = 0;

  task automatic model_reset();
    ph = P_IDLE; m_rd = 0; m_wr = 1; m_pend = 0; m_ready = 0;
    m_wr_v = 1; m_pend_v = 0; m_ready_v = 0; m_stop_done = 1; last_poll_ack = -1;
  endtask

  // One clock: serve the bus, advance the model on the edge, compare after it.
  task automatic step();
    bit ack_now = 0, busybit = 0, stb_s, latch, pickup, found;
    bit used [BN];
    int n_rd, n_pend, nw, idx;
    bit n_pend_v;
    logic [7:0] e_adr; logic e_we; logic [31:0] e_dat;
    stb_s = m_wb_stb_o;
    if (!rst && stb_s) begin
      n_cmp++;
      if (ph == P_IDLE) begin n_err++; $display("FAIL idle_bus: stb=1 while no sequence due (cycle %0d)", cyc); end
      n_cmp++;
      if (ack_prev) begin n_err++; $display("FAIL b2b_strobe: stb=1 expected 0 after ack (cycle %0d)", cyc); end
      if (!stb_prev) begin
        cap_adr = m_wb_adr_o; cap_dat = m_wb_dat_o; cap_we = m_wb_we_o; stb_age = 0;
        if (rand_mode) ack_dly = $urandom_range(0, 4);
        if (!cap_we && last_poll_ack >= 0) begin
          n_cmp++;
          if (cyc - last_poll_ack - 1 < PW) begin
            n_err++; $display("FAIL poll_gap: %0d idle cycles expected >= %0d", cyc - last_poll_ack - 1, PW);
          end
        end
      end else begin
        stb_age++;
        n_cmp++;
        if (m_wb_adr_o !== cap_adr || m_wb_dat_o !== cap_dat || m_wb_we_o !== cap_we) begin
          n_err++; $display("FAIL bus_hold: adr=%h dat=%h we=%b expected %h %h %b", m_wb_adr_o, m_wb_dat_o, m_wb_we_o, cap_adr, cap_dat, cap_we);
        end
      end
      if (stb_age >= ack_dly) ack_now = 1;
    end
    busybit = (poll_busy > 0);
    m_wb_ack_i = ack_now;
    m_wb_dat_i = $urandom;
    m_wb_dat_i[1] = busybit;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      latch = (ph == P_IDLE) && enable && m_ready_v;
      pickup = 0;
      n_rd = m_rd; n_pend = m_pend; n_pend_v = m_pend_v;
      if (latch) begin
        n_pend = m_ready; n_pend_v = 1; m_ready_v = 0; m_stop_done = 0; ph = P_ADDR; last_poll_ack = -1;
        if (rand_mode) poll_busy = $urandom_range(0, 2);
      end else if (ph == P_IDLE && !enable && !m_stop_done) ph = P_STOP;
      else if (ack_now) begin
        last_hold = stb_age + 1;
        e_adr = 8'h10; e_we = 1; e_dat = 32'h0;
        case (ph)
          P_ADDR: begin e_adr = 8'h20; e_dat = base_addr + 32'(m_pend) * buf_size; last_frame_dat = cap_dat; ph = P_CTL; end
          P_CTL:  begin e_dat = 32'h3; ph = P_POLL; end
          P_POLL: begin
            e_we = 0; poll_cnt++; last_poll_ack = cyc;
            if (busybit) poll_busy--;
            else begin pickup = 1; n_rd = m_pend; n_pend_v = 0; ph = P_IDLE; end
          end
          P_STOP: begin stop_cnt++; m_stop_done = 1; ph = P_IDLE; end
          default: ;
        endcase
        n_cmp++;
        if (cap_adr !== e_adr || cap_we !== e_we || (e_we && cap_dat !== e_dat)) begin
          n_err++; $display("FAIL bus_txn: adr=%h we=%b dat=%h expected %h %b %h", cap_adr, cap_we, cap_dat, e_adr, e_we, e_dat);
        end
      end
      if (wr_done && m_wr_v) begin
        for (int i = 0; i < BN; i++) used[i] = 0;
        used[n_rd] = 1; used[m_wr] = 1;
        if (n_pend_v) used[n_pend] = 1;
        found = 0; nw = m_wr;
        for (int k = 1; k < BN; k++) begin
          idx = (m_wr + k) % BN;
          if (!found && !used[idx]) begin found = 1; nw = idx; end
        end
        m_ready = m_wr; m_ready_v = 1;
        if (found) m_wr = nw; else m_wr_v = 0;
      end else if (!m_wr_v && pickup) begin
        m_wr = m_rd; m_wr_v = 1;
      end
      m_rd = n_rd; m_pend = n_pend; m_pend_v = n_pend_v;
    end
    stb_prev = !rst && stb_s;
    ack_prev = ack_now;
    #1;
    n_cmp++;
    if (rd_index !== IW'(m_rd)) begin n_err++; $display("FAIL rd_index: got %0d expected %0d (cycle %0d)", rd_index, m_rd, cyc); end
    n_cmp++;
    if (wr_valid !== m_wr_v) begin n_err++; $display("FAIL wr_valid: got %b expected %b (cycle %0d)", wr_valid, m_wr_v, cyc); end
    if (m_wr_v) begin
      n_cmp++;
      if (wr_index !== IW'(m_wr)) begin n_err++; $display("FAIL wr_index: got %0d expected %0d (cycle %0d)", wr_index, m_wr, cyc); end
    end
    n_cmp++;
    if (busy !== (ph != P_IDLE)) begin n_err++; $display("FAIL busy: got %b expected %b (cycle %0d)", busy, ph != P_IDLE, cyc); end
    cyc++;
    wr_done = 0;
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int limit);
    for (int i = 0; i < limit && (ph != P_IDLE || (enable && m_ready_v) || (!enable && !m_stop_done)); i++) step();
    n_cmp++;
    if (busy !== 1'b0 || ph != P_IDLE) begin n_err++; $display("FAIL idle_timeout: busy=%b expected 0 within %0d cycles", busy, limit); end
  endtask

  task automatic pulse_wr();
    wr_done = 1; step();
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; wr_done = 0; m_wb_ack_i = 0; m_wb_dat_i = '0;
    base_addr = 32'h1000_0000; buf_size = 32'h0010_0000;
    step(); step();
    rst = 0;
    n_cmp++;
    if (rd_index !== 2'd0 || wr_index !== 2'd1 || wr_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idx: rd=%0d wr=%0d wv=%b busy=%b expected 0 1 1 0", rd_index, wr_index, wr_valid, busy);
    end
    n_cmp++;
    if (m_wb_stb_o !== 1'b0 || m_wb_we_o !== 1'b0 || m_wb_adr_o !== 8'h0 || m_wb_dat_o !== 32'h0 || m_wb_sel_o !== 4'hf) begin
      n_err++; $display("FAIL reset_bus: stb=%b we=%b adr=%h dat=%h sel=%h expected 0 0 00 0 f", m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_dat_o, m_wb_sel_o);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_single_update();
    enable = 1; ack_dly = 0; poll_busy = 0; poll_cnt = 0;
    pulse_wr();
    run_until_idle(200);
    n_cmp++;
    if (last_frame_dat !== 32'h1010_0000) begin n_err++; $display("FAIL frame_addr: got %h expected 10100000", last_frame_dat); end
    n_cmp++;
    if (rd_index !== 2'd1 || wr_index !== 2'd2 || poll_cnt != 1) begin
      n_err++; $display("FAIL single_update: rd=%0d wr=%0d polls=%0d expected 1 2 1", rd_index, wr_index, poll_cnt);
    end
  endtask

  task automatic test_poll_retry();
    poll_busy = 2; poll_cnt = 0;
    pulse_wr();
    run_until_idle(300);
    n_cmp++;
    if (poll_cnt != 3 || rd_index !== 2'd2 || wr_index !== 2'd0) begin
      n_err++; $display("FAIL poll_retry: polls=%0d rd=%0d wr=%0d expected 3 2 0", poll_cnt, rd_index, wr_index);
    end
  endtask

  task automatic test_three_pulses();
    rst = 1; step(); rst = 0;
    enable = 1; ack_dly = 3; poll_busy = 1;
    pulse_wr();
    step();
    pulse_wr();
    n_cmp++;
    if (wr_valid !== 1'b0) begin n_err++; $display("FAIL full_after_second: wr_valid=%b expected 0", wr_valid); end
    step();
    pulse_wr();
    n_cmp++;
    if (wr_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL third_ignored: wr_valid=%b busy=%b expected 0 1", wr_valid, busy); end
    for (int i = 0; i < 300 && rd_index === 2'd0; i++) step();
    n_cmp++;
    if (rd_index !== 2'd1 || wr_valid !== 1'b1 || wr_index !== 2'd0) begin
      n_err++; $display("FAIL pickup_frees: rd=%0d wv=%b wr=%0d expected 1 1 0", rd_index, wr_valid, wr_index);
    end
    run_until_idle(300);
  endtask

  task automatic test_ack_delay();
    ack_dly = 5; poll_busy = 0;
    pulse_wr();
    run_until_idle(300);
    n_cmp++;
    if (last_hold != 6) begin n_err++; $display("FAIL ack_delay_hold: stb held %0d cycles expected 6", last_hold); end
    ack_dly = 0;
  endtask

  task automatic test_stop_in_wait();
    ack_dly = 1; poll_busy = 1; poll_cnt = 0; stop_cnt = 0;
    pulse_wr();
    for (int i = 0; i < 200 && !(poll_cnt == 1 && ph == P_POLL && !m_wb_stb_o); i++) step();
    enable = 0;
    run_until_idle(300);
    for (int i = 0; i < 60; i++) step();
    n_cmp++;
    if (stop_cnt != 1 || poll_cnt != 2 || busy !== 1'b0) begin
      n_err++; $display("FAIL stop_after_wait: stops=%0d polls=%0d busy=%b expected 1 2 0", stop_cnt, poll_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_ctl();
    enable = 1; ack_dly = 0; poll_busy = 0;
    pulse_wr();
    for (int i = 0; i < 100 && ph != P_CTL; i++) step();
    ack_dly = 50;
    for (int i = 0; i < 10 && !m_wb_stb_o; i++) step();
    step();
    rst = 1; step(); rst = 0;
    n_cmp++;
    if (m_wb_stb_o !== 1'b0 || rd_index !== 2'd0 || wr_index !== 2'd1 || wr_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_ctl: stb=%b rd=%0d wr=%0d wv=%b busy=%b expected 0 0 1 1 0", m_wb_stb_o, rd_index, wr_index, wr_valid, busy);
    end
    ack_dly = 0;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_random();
    rand_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      wr_done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if (!enable && ph == P_IDLE && $urandom_range(0, 3) == 0) begin
        base_addr = $urandom & 32'hffff_f000;
        buf_size  = $urandom_range(1, 4096) << 8;
      end
      step();
    end
    enable = 1;
    run_until_idle(400);
    rand_mode = 0;
  endtask

  initial begin
    rst = 1; enable = 0; wr_done = 0; m_wb_ack_i = 0; m_wb_dat_i = '0;
    base_addr = '0; buf_size = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_update();
    test_poll_retry();
    test_three_pulses();
    test_ack_delay();
    test_stop_in_wait();
    test_reset_mid_ctl();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
